// File: rtl/memory_access_stage.sv
// ---------------------------------------------------------------------------
// memory_access_stage
//
// Memory-access pipeline stage between execute and writeback. Takes one op at
// a time (load, store or pass-through), issues it to a variable-latency data
// memory with byte strobes, and hands writeback either the extended load
// data or the bypassed ALU result. Misaligned and illegal ops are reported
// instead of being issued.
//
// Optional feature macro: MEMACC_TIMEOUT_EN
//   defined   : a watchdog counter turns a request/response that has been
//               outstanding for TIMEOUT cycles into an err_bus completion.
//   undefined : no counter, err_bus tied 0, the stage waits indefinitely.
//
// Parameters
//   XLEN     datapath width (32 or 64)
//   TIMEOUT  watchdog limit in cycles (>= 1; watchdog build only)
//
// Ports
//   clk, rst                          clock, async active-high reset
//   in_valid / in_ready               op handshake from execute
//   in_read_en, in_write_en           load / store select (neither = bypass)
//   in_addr, in_wdata, in_size        address-or-data, store data, size code
//   req_valid / req_ready             memory request handshake
//   req_we, req_addr, req_wdata,
//   req_wstrb                         request fields (aligned word + lanes)
//   rsp_valid, rsp_data               load response (full aligned word)
//   out_valid, out_data               one-cycle completion pulse + result
//   err_misaligned, err_illegal,
//   err_bus                           error qualifiers, valid with out_valid
//   dbg_state                         current FSM state (0 IDLE, 1 REQ, 2 RSP)
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both 1; valid is never withdrawn and its fields never change until
// that transfer happens. in_ready is 1 only in IDLE, so at most one op is in
// flight and back-pressure to execute comes only through in_ready.
// ---------------------------------------------------------------------------
module memory_access_stage #(
   parameter int XLEN    = 64,
   parameter int TIMEOUT = 255,
   localparam int LANES  = XLEN / 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_read_en,
   input  logic             in_write_en,
   input  logic [XLEN-1:0]  in_addr,
   input  logic [XLEN-1:0]  in_wdata,
   input  logic [2:0]       in_size,
   output logic             req_valid,
   input  logic             req_ready,
   output logic             req_we,
   output logic [XLEN-1:0]  req_addr,
   output logic [XLEN-1:0]  req_wdata,
   output logic [LANES-1:0] req_wstrb,
   input  logic             rsp_valid,
   input  logic [XLEN-1:0]  rsp_data,
   output logic             out_valid,
   output logic [XLEN-1:0]  out_data,
   output logic             err_misaligned,
   output logic             err_illegal,
   output logic             err_bus,
   output logic [1:0]       dbg_state
);

   localparam int OFS = $clog2(LANES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RSP  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_nxt_state;

   logic               r_in_ready;
   logic               r_req_valid;
   logic               r_req_we;
   logic [XLEN-1:0]    r_req_addr;
   logic [XLEN-1:0]    r_req_wdata;
   logic [LANES-1:0]   r_req_wstrb;
   logic [2:0]         r_ld_size;
   logic [OFS-1:0]     r_ld_off;
   logic               r_out_valid;
   logic [XLEN-1:0]    r_out_data;
   logic               r_err_mis;
   logic               r_err_ill;

   logic               w_accept;
   logic               w_issue;
   logic               w_mem_op;
   logic               w_illegal;
   logic               w_misaligned;
   logic [OFS-1:0]     w_off;
   logic [XLEN-1:0]    w_st_wdata;
   logic [LANES-1:0]   w_st_base;
   logic [LANES-1:0]   w_st_strb;
   logic [XLEN-1:0]    w_rsp_shift;
   logic [XLEN-1:0]    w_ld_data;

   logic               w_nxt_out_valid;
   logic [XLEN-1:0]    w_nxt_out_data;
   logic               w_nxt_err_mis;
   logic               w_nxt_err_ill;

`ifdef MEMACC_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CW-1:0]      r_cnt;
   logic               r_err_bus;
   logic               w_timeout;
   logic               w_nxt_err_bus;
`endif

   // ------------------------------------------------------------------
   // Op decode (only meaningful in IDLE while in_valid is high)
   // ------------------------------------------------------------------
   assign w_accept = in_valid & r_in_ready;
   assign w_mem_op = in_read_en | in_write_en;
   assign w_off    = in_addr[OFS-1:0];

   // D (code 3) is only legal when the datapath is 64 bits wide.
   assign w_illegal = (in_read_en & in_write_en)
                    | (in_size == 3'd7)
                    | (in_write_en & (in_size > 3'd3))
                    | ((in_size == 3'd3) & (XLEN == 32));

   always_comb begin
      w_misaligned = 1'b0;
      case (in_size)
         3'd1, 3'd5: w_misaligned = in_addr[0];
         3'd2, 3'd6: w_misaligned = |in_addr[1:0];
         3'd3:       w_misaligned = |in_addr[2:0];
         default:    w_misaligned = 1'b0;
      endcase
      w_misaligned = w_misaligned & w_mem_op;
   end

   // Store data and strobes are steered into the lanes the address selects.
   assign w_st_wdata = in_wdata << {w_off, 3'b000};

   always_comb begin
      w_st_base = '0;
      case (in_size[1:0])
         2'd0:    w_st_base = LANES'(8'h01);
         2'd1:    w_st_base = LANES'(8'h03);
         2'd2:    w_st_base = LANES'(8'h0F);
         default: w_st_base = LANES'(8'hFF);
      endcase
   end

   assign w_st_strb = w_st_base << w_off;

   // ------------------------------------------------------------------
   // Load extraction: bring the addressed bytes down to bit 0, then
   // truncate and extend. Size casts of a signed slice sign-extend.
   // ------------------------------------------------------------------
   assign w_rsp_shift = rsp_data >> {r_ld_off, 3'b000};

   always_comb begin
      w_ld_data = '0;
      case (r_ld_size)
         3'd0:    w_ld_data = XLEN'(signed'(w_rsp_shift[7:0]));
         3'd1:    w_ld_data = XLEN'(signed'(w_rsp_shift[15:0]));
         3'd2:    w_ld_data = XLEN'(signed'(w_rsp_shift[31:0]));
         3'd3:    w_ld_data = w_rsp_shift;
         3'd4:    w_ld_data = XLEN'(w_rsp_shift[7:0]);
         3'd5:    w_ld_data = XLEN'(w_rsp_shift[15:0]);
         3'd6:    w_ld_data = XLEN'(w_rsp_shift[31:0]);
         default: w_ld_data = '0;
      endcase
   end

`ifdef MEMACC_TIMEOUT_EN
   // Counter is 0 in the first REQ cycle, so firing at TIMEOUT-1 puts the
   // err_bus pulse exactly TIMEOUT cycles after REQ entry.
   assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
`endif

   // ------------------------------------------------------------------
   // FSM next-state and next-output logic
   // ------------------------------------------------------------------
   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_out_valid = 1'b0;
      w_nxt_out_data  = '0;
      w_nxt_err_mis   = 1'b0;
      w_nxt_err_ill   = 1'b0;
`ifdef MEMACC_TIMEOUT_EN
      w_nxt_err_bus   = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_illegal) begin
                  w_nxt_out_valid = 1'b1;
                  w_nxt_err_ill   = 1'b1;
               end else if (w_misaligned) begin
                  w_nxt_out_valid = 1'b1;
                  w_nxt_err_mis   = 1'b1;
               end else if (!w_mem_op) begin
                  w_nxt_out_valid = 1'b1;
                  w_nxt_out_data  = in_addr;
               end else begin
                  w_nxt_state = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (req_ready) begin
               if (r_req_we) begin
                  w_nxt_out_valid = 1'b1;
                  w_nxt_state     = S_IDLE;
               end else begin
                  w_nxt_state = S_RSP;
               end
            end
`ifdef MEMACC_TIMEOUT_EN
            else if (w_timeout) begin
               w_nxt_out_valid = 1'b1;
               w_nxt_err_bus   = 1'b1;
               w_nxt_state     = S_IDLE;
            end
`endif
         end
         S_RSP: begin
            if (rsp_valid) begin
               w_nxt_out_valid = 1'b1;
               w_nxt_out_data  = w_ld_data;
               w_nxt_state     = S_IDLE;
            end
`ifdef MEMACC_TIMEOUT_EN
            else if (w_timeout) begin
               w_nxt_out_valid = 1'b1;
               w_nxt_err_bus   = 1'b1;
               w_nxt_state     = S_IDLE;
            end
`endif
         end
         default: w_nxt_state = S_IDLE;
      endcase
   end

   assign w_issue = (r_state == S_IDLE) & (w_nxt_state == S_REQ);

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_req_valid <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_err_mis   <= 1'b0;
         r_err_ill   <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_in_ready  <= (w_nxt_state == S_IDLE);
         r_req_valid <= (w_nxt_state == S_REQ);
         r_out_valid <= w_nxt_out_valid;
         r_out_data  <= w_nxt_out_data;
         r_err_mis   <= w_nxt_err_mis;
         r_err_ill   <= w_nxt_err_ill;
      end
   end

   // Request fields are captured once at issue and held until completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_we    <= 1'b0;
         r_req_addr  <= '0;
         r_req_wdata <= '0;
         r_req_wstrb <= '0;
         r_ld_size   <= 3'd0;
         r_ld_off    <= '0;
      end else if (w_issue) begin
         r_req_we    <= in_write_en;
         r_req_addr  <= {in_addr[XLEN-1:OFS], {OFS{1'b0}}};
         r_req_wdata <= in_write_en ? w_st_wdata : '0;
         r_req_wstrb <= in_write_en ? w_st_strb : '0;
         r_ld_size   <= in_size;
         r_ld_off    <= w_off;
      end
   end

`ifdef MEMACC_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_err_bus <= 1'b0;
      end else begin
         r_err_bus <= w_nxt_err_bus;
         if (w_issue) begin
            r_cnt <= '0;
         end else if (r_state != S_IDLE) begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign err_bus = r_err_bus;
`else
   assign err_bus = 1'b0;
`endif

   assign in_ready       = r_in_ready;
   assign req_valid      = r_req_valid;
   assign req_we         = r_req_we;
   assign req_addr       = r_req_addr;
   assign req_wdata      = r_req_wdata;
   assign req_wstrb      = r_req_wstrb;
   assign out_valid      = r_out_valid;
   assign out_data       = r_out_data;
   assign err_misaligned = r_err_mis;
   assign err_illegal    = r_err_ill;
   assign dbg_state      = r_state;

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Parametrised, handshaked memory-access pipeline stage sitting between execute and writeback. Accepts one load, store or pass-through op at a time, drives a variable-latency data-memory request/response port with byte strobes, and returns sign/zero-extended load data or the bypassed ALU result to writeback. Flags misaligned and illegal ops instead of issuing them; an optional watchdog converts a hung memory into a bus error.

## Interface
- XLEN, 64: datapath width, 32 or 64; LANES = XLEN/8, OFS = log2(LANES).
- TIMEOUT, 255: watchdog limit in cycles, only used with the watchdog macro.
- clk  in  1  clock; everything on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid / in_ready  in / out  1 / 1  op handshake from execute.
- in_read_en, in_write_en  in  1 each  load / store select.
- in_addr  in  XLEN  ALU result: address for loads and stores, data for pass-through.
- in_wdata  in  XLEN  store data, right-aligned.
- in_size  in  3  0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU; stores use codes 0-3.
- req_valid / req_ready  out / in  1 / 1  memory request handshake.
- req_we  out  1  1 store, 0 load.
- req_addr  out  XLEN  in_addr with low OFS bits cleared.
- req_wdata  out  XLEN  store data shifted into its lanes.
- req_wstrb  out  LANES  byte-enable mask.
- rsp_valid, rsp_data  in  1, XLEN  load response, full aligned word.
- out_valid  out  1  one-cycle completion pulse to writeback.
- out_data  out  XLEN  extended load data or bypassed in_addr; 0 for stores and errors.
- err_misaligned, err_illegal, err_bus  out  1 each  error qualifiers, valid with out_valid.

## Operation
- FSM states: IDLE, REQ, RSP. in_ready = 1 only in IDLE.
- IDLE accept (in_valid & in_ready):
  - Both enables set, size code 7, store size > 3, or size D with XLEN=32: err_illegal pulse, stay IDLE.
  - Misaligned (H: addr[0]; W: addr[1:0]; D: addr[2:0] nonzero): err_misaligned pulse, stay IDLE, no request issued.
  - Neither enable: out_data = in_addr, stay IDLE.
  - Otherwise latch op and go to REQ.
- REQ: req_valid = 1, request fields stable until req_ready. On req_ready, a store pulses out_valid and returns to IDLE; a load goes to RSP.
- RSP: wait for rsp_valid; the value is rsp_data >> (8*offset), truncated to size and sign- or zero-extended per in_size. out_valid pulses, return to IDLE.
- Store lanes: req_wdata = in_wdata << (8*offset); req_wstrb = {1,3,F,FF}[size] << offset.
- rsp_valid outside RSP is ignored.

## Timing
- All outputs registered. Reset values: in_ready 1; everything else 0; state IDLE; counter 0.
- Pass-through and error ops: accept in cycle N, out_valid in N+1. Next accept is possible in N+1.
- Store: accept N, req_valid from N+1; with req_ready=1 in N+1, out_valid in N+2.
- Load: accept N, req N+1 (ready), rsp_valid N+2, out_valid N+3.
- One transaction outstanding at most; back-pressure comes only through in_ready.
- rst asserted mid-transaction: FSM goes to IDLE, req_valid drops immediately, and any in-flight response is discarded.

## Configuration
- MEMACC_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter clears on entry to REQ and counts every cycle in REQ or RSP.
  - When the count reaches TIMEOUT: err_bus pulses with out_valid, out_data = 0, FSM returns to IDLE, and req_valid drops.
- MEMACC_TIMEOUT_EN undefined: no counter. err_bus is tied 0 and the FSM waits indefinitely.

## Test plan
- LH, XLEN=64, addr 0x1006, rsp_data 0x8001_xxxx_xxxx_xxxx: req_addr 0x1000, out_data 0xFFFF_FFFF_FFFF_8001, out_valid at N+3. Repeat as LHU: out_data 0x8001.
- SB, addr 0x2003, wdata 0xAB: req_wstrb 0x08, req_wdata byte 3 = 0xAB; req_ready held low 4 cycles keeps all request fields stable; out_valid one cycle after the handshake.
- LW at addr 0x3002: err_misaligned with out_valid at N+1, req_valid never rises. Both enables set: err_illegal.
- Pass-through in_addr 0x1234 on back-to-back cycles: out_data 0x1234 each following cycle, in_ready stays 1.
- With MEMACC_TIMEOUT_EN and TIMEOUT=16, load with no rsp_valid: err_bus pulses 16 cycles after REQ entry. A later stray rsp_valid is ignored.
- rst asserted while in RSP: outputs return to reset values and a later rsp_valid produces no out_valid.
